pdm_capture_controller: RTL and testbench

//  Sequences one PDM microphone capture. Gates and configures the PDM interface: enable, clock divisor and channel select.

---
 rtl/pdm_capture_controller_if.sv | 30 +++
 rtl/pdm_capture_controller.sv | 172 +++++++++++++++++
 tb/tb_pdm_capture_controller.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pdm_capture_controller_if.sv
// Purpose: PCM sample stream from the decimator and the write side of the
//   sample buffer, bundled for the capture controller.
// Signals:
//   pcm_valid    decimator sample strobe
//   pcm_data     decimator sample
//   pcm_channel  channel of the sample (0=LEFT)
//   buf_full     buffer cannot accept a write
//   buf_push     buffer write strobe
//   buf_data     {channel, sample} written into the buffer
// Modports: master = capture controller, slave = decimator/buffer side.
interface pdm_capture_controller_if #(
  parameter int PCM_WIDTH = 16
);
  logic                 pcm_valid;
  logic [PCM_WIDTH-1:0] pcm_data;
  logic                 pcm_channel;
  logic                 buf_full;
  logic                 buf_push;
  logic [PCM_WIDTH:0]   buf_data;

  modport master (
    input  pcm_valid, pcm_data, pcm_channel, buf_full,
    output buf_push, buf_data
  );

  modport slave (
    output pcm_valid, pcm_data, pcm_channel, buf_full,
    input  buf_push, buf_data
  );
endinterface

// File: rtl/pdm_capture_controller.sv
// Purpose: sequences one PDM microphone capture. On start it latches the
//   interface configuration, enables the PDM interface and flushes the
//   decimator, waits a warm-up time, drops the first PCM samples while the
//   decimator settles, then forwards a programmed number of samples (or runs
//   until stopped) into the sample buffer, tracking overflow on a full buffer.
// Ports:
//   clk_i, rst_n_i       clock; asynchronous active-low reset
//   start_i, stop_i      capture start / abort pulses
//   cfg_*_i              divisor, dual/channel select, warm-up, discard, target
//   intf_*_o             latched PDM interface enable and configuration
//   decim_clear_o        one-cycle decimator flush at capture start
//   stream               PCM input stream and buffer write port (master)
//   busy_o, state_o      activity flag and FSM state encoding
//   sample_count_o       samples stored during the current/last capture
//   done_o               one-cycle completion pulse
//   overflow_o           sticky dropped-sample flag, cleared by clear_ovf_i
module pdm_capture_controller #(
  parameter int DIV_WIDTH    = 7,
  parameter int PCM_WIDTH    = 16,
  parameter int COUNT_WIDTH  = 16,
  parameter int WARMUP_WIDTH = 20
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic [DIV_WIDTH-1:0]    cfg_divisor_i,
  input  logic                    cfg_dual_i,
  input  logic                    cfg_channel_i,
  input  logic [WARMUP_WIDTH-1:0] cfg_warmup_i,
  input  logic [7:0]              cfg_discard_i,
  input  logic [COUNT_WIDTH-1:0]  cfg_target_i,
  output logic                    intf_clk_en_o,
  output logic [DIV_WIDTH-1:0]    intf_divisor_o,
  output logic                    intf_dual_o,
  output logic                    intf_channel_o,
  output logic                    decim_clear_o,
  output logic                    busy_o,
  output logic [2:0]              state_o,
  output logic [COUNT_WIDTH-1:0]  sample_count_o,
  output logic                    done_o,
  output logic                    overflow_o,
  input  logic                    clear_ovf_i,
  pdm_capture_controller_if.master stream
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WARMUP  = 3'd1,
    DISCARD = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                  state;
  logic [WARMUP_WIDTH-1:0] warmup_cnt;
  logic [7:0]              discard_cnt;
  logic [7:0]              discard_lat;
  logic [COUNT_WIDTH-1:0]  target_lat;

  logic                    push_ok;
  logic                    ovf_event;
  logic [COUNT_WIDTH-1:0]  count_next;
  logic [7:0]              discard_next;

  // The buffer write is combinational so a sample is stored in the same
  // cycle the decimator presents it; a full buffer turns it into an overflow.
  assign push_ok      = (state == CAPTURE) && stream.pcm_valid && !stream.buf_full;
  assign ovf_event    = (state == CAPTURE) && stream.pcm_valid && stream.buf_full;
  assign count_next   = sample_count_o + 1'b1;
  assign discard_next = discard_cnt + 1'b1;

  assign stream.buf_push = push_ok;
  assign stream.buf_data = {stream.pcm_channel, stream.pcm_data};

  assign busy_o  = (state != IDLE);
  assign state_o = state;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= IDLE;
      warmup_cnt     <= '0;
      discard_cnt    <= '0;
      discard_lat    <= '0;
      target_lat     <= '0;
      intf_clk_en_o  <= 1'b0;
      intf_divisor_o <= '0;
      intf_dual_o    <= 1'b0;
      intf_channel_o <= 1'b0;
      decim_clear_o  <= 1'b0;
      sample_count_o <= '0;
      done_o         <= 1'b0;
      overflow_o     <= 1'b0;
    end else begin
      decim_clear_o <= 1'b0;
      done_o        <= 1'b0;

      // A drop in the same cycle as a clear request keeps the flag set.
      if (ovf_event) begin
        overflow_o <= 1'b1;
      end else if (clear_ovf_i) begin
        overflow_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          // A simultaneous stop cancels the start.
          if (start_i && !stop_i) begin
            intf_divisor_o <= cfg_divisor_i;
            intf_dual_o    <= cfg_dual_i;
            intf_channel_o <= cfg_channel_i;
            discard_lat    <= cfg_discard_i;
            target_lat     <= cfg_target_i;
            warmup_cnt     <= cfg_warmup_i;
            discard_cnt    <= '0;
            sample_count_o <= '0;
            decim_clear_o  <= 1'b1;
            intf_clk_en_o  <= 1'b1;
            state          <= WARMUP;
          end
        end

        WARMUP: begin
          // The terminal-count cycle is itself a warm-up cycle, so a
          // warm-up of W lasts W+1 cycles.
          if (stop_i) begin
            intf_clk_en_o <= 1'b0;
            state         <= IDLE;
          end else if (warmup_cnt == '0) begin
            state <= (discard_lat == '0) ? CAPTURE : DISCARD;
          end else begin
            warmup_cnt <= warmup_cnt - 1'b1;
          end
        end

        DISCARD: begin
          if (stop_i) begin
            intf_clk_en_o <= 1'b0;
            state         <= IDLE;
          end else if (stream.pcm_valid) begin
            discard_cnt <= discard_next;
            if (discard_next == discard_lat) begin
              state <= CAPTURE;
            end
          end
        end

        CAPTURE: begin
          // A target of zero means continuous capture; only stop ends it.
          if (push_ok) begin
            sample_count_o <= count_next;
          end
          if (stop_i || (push_ok && (target_lat != '0) && (count_next == target_lat))) begin
            intf_clk_en_o <= 1'b0;
            done_o        <= 1'b1;
            state         <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          intf_clk_en_o <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_capture_controller.sv
// Purpose: randomized self-checking bench for pdm_capture_controller.
//   A stimulus task drives captures cycle by cycle and derives the expected
//   buffer writes from the capture rules (warm-up length, discard count,
//   target, stop, full buffer), queuing each expected word; a monitor pops
//   and compares whenever the controller writes the buffer.
module tb_pdm_capture_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear_ovf = 1'b0;
  logic [6:0]  cfg_divisor = '0;
  logic        cfg_dual = 1'b0;
  logic        cfg_channel = 1'b0;
  logic [19:0] cfg_warmup = '0;
  logic [7:0]  cfg_discard = '0;
  logic [15:0] cfg_target = '0;

  logic        intf_clk_en;
  logic [6:0]  intf_divisor;
  logic        intf_dual;
  logic        intf_channel;
  logic        decim_clear;
  logic        busy;
  logic [2:0]  state;
  logic [15:0] sample_count;
  logic        done;
  logic        overflow;

  pdm_capture_controller_if #(.PCM_WIDTH(16)) stream ();

  pdm_capture_controller #(
    .DIV_WIDTH(7), .PCM_WIDTH(16), .COUNT_WIDTH(16), .WARMUP_WIDTH(20)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop),
    .cfg_divisor_i(cfg_divisor), .cfg_dual_i(cfg_dual), .cfg_channel_i(cfg_channel),
    .cfg_warmup_i(cfg_warmup), .cfg_discard_i(cfg_discard), .cfg_target_i(cfg_target),
    .intf_clk_en_o(intf_clk_en), .intf_divisor_o(intf_divisor), .intf_dual_o(intf_dual),
    .intf_channel_o(intf_channel), .decim_clear_o(decim_clear), .busy_o(busy),
    .state_o(state), .sample_count_o(sample_count), .done_o(done),
    .overflow_o(overflow), .clear_ovf_i(clear_ovf), .stream(stream)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_word;
  int          dones_seen = 0;
  int          dones_exp = 0;
  bit          ovf_exp = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every buffer write must match the oldest expected word.
  always @(negedge clk) begin
    if (done === 1'b1) dones_seen++;
    if (stream.buf_push === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_push: got %0h expected no write", stream.buf_data);
      end else begin
        mon_word = exp_q.pop_front();
        checkOutput("buf_data", 32'(stream.buf_data), 32'(mon_word));
      end
    end
  end

  // One capture: w/d/t configure it; valid_pct, full_on_valid (index among
  // post-warm-up strobes), full_pct, stop_at (cycle after start, 0=never)
  // and clr_pct shape the stream.
  task automatic applyStimulus(input int w, input int d, input int t, input int valid_pct,
                               input int full_on_valid, input int full_pct, input int stop_at,
                               input int clr_pct, input int max_cycles);
    int         vi, stored, count_before;
    bit         finished, aborted, in_warm, in_cap, v, f, evt, ovf_before;
    logic [6:0] dv;
    logic       du, ch;
    vi = 0; stored = 0; finished = 0; aborted = 0;
    dv = 7'($urandom); du = 1'($urandom); ch = 1'($urandom);
    @(posedge clk); #1;
    cfg_divisor = dv; cfg_dual = du; cfg_channel = ch;
    cfg_warmup = 20'(w); cfg_discard = 8'(d); cfg_target = 16'(t);
    start = 1'b1;
    for (int k = 1; k <= max_cycles && !finished && !aborted; k++) begin
      @(posedge clk); #1;
      cfg_divisor = 7'($urandom); cfg_dual = 1'($urandom); cfg_channel = 1'($urandom);
      cfg_warmup = 20'($urandom); cfg_discard = 8'($urandom); cfg_target = 16'($urandom);
      start = ($urandom_range(0, 99) < 10);
      stop = (k == stop_at);
      clear_ovf = ($urandom_range(0, 99) < clr_pct);
      in_warm = (k <= w + 1);
      v = ($urandom_range(0, 99) < valid_pct);
      f = (!in_warm && v && (vi + 1 == full_on_valid)) || ($urandom_range(0, 99) < full_pct);
      stream.pcm_valid = v;
      stream.buf_full = f;
      stream.pcm_data = 16'($urandom);
      stream.pcm_channel = 1'($urandom);
      ovf_before = ovf_exp;
      count_before = stored;
      in_cap = !in_warm && (vi >= d);
      evt = 1'b0;
      if (in_warm) begin
        if (stop) aborted = 1'b1;
      end else if (stop && !in_cap) begin
        aborted = 1'b1;
      end else begin
        if (v) begin
          vi++;
          if (in_cap) begin
            if (f) evt = 1'b1;
            else begin
              exp_q.push_back({stream.pcm_channel, stream.pcm_data});
              stored++;
            end
          end
        end
        if (in_cap && (stop || (t != 0 && stored == t))) finished = 1'b1;
      end
      if (evt) ovf_exp = 1'b1;
      else if (clear_ovf) ovf_exp = 1'b0;

      @(negedge clk);
      checkOutput("state", 32'(state), in_warm ? 32'd1 : (in_cap ? 32'd3 : 32'd2));
      checkOutput("decim_clear", 32'(decim_clear), 32'(k == 1));
      checkOutput("clk_en_run", 32'(intf_clk_en), 32'd1);
      checkOutput("busy_run", 32'(busy), 32'd1);
      checkOutput("count_run", 32'(sample_count), 32'(count_before & 32'hFFFF));
      checkOutput("overflow_run", 32'(overflow), 32'(ovf_before));
      if (k == 1) begin
        checkOutput("divisor_latch", 32'(intf_divisor), 32'(dv));
        checkOutput("dual_latch", 32'(intf_dual), 32'(du));
        checkOutput("channel_latch", 32'(intf_channel), 32'(ch));
      end
    end
    if (!finished && !aborted) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: capture still running after %0d cycles", max_cycles);
    end
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; clear_ovf = 1'b0;
    stream.pcm_valid = 1'b0; stream.buf_full = 1'b0;
    @(negedge clk);
    if (finished) begin
      dones_exp++;
      checkOutput("state_done", 32'(state), 32'd4);
      checkOutput("done_pulse", 32'(done), 32'd1);
      checkOutput("clk_en_done", 32'(intf_clk_en), 32'd0);
    end else begin
      checkOutput("state_abort", 32'(state), 32'd0);
      checkOutput("done_abort", 32'(done), 32'd0);
      checkOutput("clk_en_abort", 32'(intf_clk_en), 32'd0);
    end
    checkOutput("overflow_end", 32'(overflow), 32'(ovf_exp));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("state_idle", 32'(state), 32'd0);
    checkOutput("busy_idle", 32'(busy), 32'd0);
    checkOutput("done_idle", 32'(done), 32'd0);
    checkOutput("count_hold", 32'(sample_count), 32'(stored & 32'hFFFF));
    checkOutput("divisor_hold", 32'(intf_divisor), 32'(dv));
    checkOutput("dual_hold", 32'(intf_dual), 32'(du));
    checkOutput("channel_hold", 32'(intf_channel), 32'(ch));
    checkOutput("done_pulses", 32'(dones_seen), 32'(dones_exp));
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_state"}, 32'(state), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_clk_en"}, 32'(intf_clk_en), 32'd0);
    checkOutput({tag, "_divisor"}, 32'(intf_divisor), 32'd0);
    checkOutput({tag, "_dual"}, 32'(intf_dual), 32'd0);
    checkOutput({tag, "_channel"}, 32'(intf_channel), 32'd0);
    checkOutput({tag, "_decim_clear"}, 32'(decim_clear), 32'd0);
    checkOutput({tag, "_count"}, 32'(sample_count), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
    checkOutput({tag, "_push"}, 32'(stream.buf_push), 32'd0);
  endtask

  initial begin
    stream.pcm_valid = 1'b0;
    stream.buf_full = 1'b0;
    stream.pcm_data = '0;
    stream.pcm_channel = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    $display("[TB] reset released");

    // Directed scenarios.
    applyStimulus(10, 2, 4, 50, 0, 0, 0, 0, 500);
    applyStimulus(10, 2, 4, 50, 4, 0, 0, 0, 500);
    @(posedge clk); #1; clear_ovf = 1'b1;
    @(posedge clk); #1; clear_ovf = 1'b0; ovf_exp = 1'b0;
    @(negedge clk);
    checkOutput("overflow_cleared", 32'(overflow), 32'd0);
    applyStimulus(0, 0, 1, 100, 0, 0, 0, 0, 50);
    applyStimulus(20, 2, 4, 50, 0, 0, 5, 0, 100);
    applyStimulus(2, 5, 4, 50, 0, 0, 8, 0, 100);

    // Start and stop together while idle: no capture begins.
    @(posedge clk); #1; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1; start = 1'b0; stop = 1'b0;
    @(negedge clk);
    checkOutput("start_stop_state", 32'(state), 32'd0);
    checkOutput("start_stop_clk_en", 32'(intf_clk_en), 32'd0);
    checkOutput("start_stop_clear", 32'(decim_clear), 32'd0);

    // Randomized captures including full buffer, clear requests and stops.
    for (int r = 0; r < 8; r++) begin
      applyStimulus(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), int'($urandom_range(1, 8)),
                    int'($urandom_range(30, 100)), 0, 25, (r % 3 == 2) ? int'($urandom_range(2, 15)) : 0,
                    20, 1000);
    end

    // Continuous capture wraps the count.
    applyStimulus(0, 0, 0, 100, 0, 0, 70001, 0, 70100);

    // Asynchronous reset in the middle of a capture.
    @(posedge clk); #1;
    cfg_divisor = 7'h55; cfg_dual = 1'b1; cfg_channel = 1'b1;
    cfg_warmup = '0; cfg_discard = '0; cfg_target = '0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; stream.pcm_valid = 1'b1; stream.buf_full = 1'b1;
    @(posedge clk); #1; stream.pcm_valid = 1'b0; stream.buf_full = 1'b0;
    @(negedge clk);
    checkOutput("pre_reset_state", 32'(state), 32'd3);
    checkOutput("pre_reset_overflow", 32'(overflow), 32'd1);
    checkOutput("pre_reset_divisor", 32'(intf_divisor), 32'h55);
    @(posedge clk); #2; rst_n = 1'b0; #1;
    checkResetOutputs("async_reset");
    ovf_exp = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    applyStimulus(0, 0, 1, 100, 0, 0, 0, 0, 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
